flex_down_timer: RTL and testbench
==================================

FLEX_DOWN_TIMER -- requirements
Module: flex_down_timer

Interface
REQ-001 Parameter SHALL be: NUM_CNT_BITS, default 4, width of load value, reload register and count.
REQ-002 Port SHALL be: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port SHALL be: n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port SHALL be: clear  input  1  synchronous abort; count to 0, state to IDLE.
REQ-005 Port SHALL be: load  input  1  synchronous load of load_val into count and reload register.
REQ-006 Port SHALL be: count_enable  input  1  decrement strobe; ignored outside RUN.
REQ-007 Port SHALL be: periodic  input  1  1 = auto-reload on expiry, 0 = one-shot.
REQ-008 Port SHALL be: load_val  input  NUM_CNT_BITS  start/reload value, unsigned.
REQ-009 Port SHALL be: count_out  output  NUM_CNT_BITS  current count, registered.
REQ-010 Port SHALL be: expire_flag  output  1  one-cycle registered pulse on terminal decrement.
REQ-011 Port SHALL be: busy  output  1  high when state is RUN, registered.

Function
REQ-012 States SHALL be IDLE, RUN and DONE, held in a registered state variable.
REQ-013 Priority SHALL be clear > load > count_enable, evaluated every cycle in every state.
REQ-014 clear SHALL set count_out=0, expire_flag=0 and state=IDLE next cycle; the reload register keeps its value.
REQ-015 load with load_val!=0 SHALL set count_out=load_val, reload register=load_val, state=RUN and expire_flag=0 next cycle, from any state, including a restart mid-count.
REQ-016 load with load_val==0 SHALL set count_out=0, reload register=0, state=IDLE and expire_flag=0; no expiry is generated.
REQ-017 In RUN with count_enable=1 and count_out>1, count_out SHALL decrement by 1 next cycle.
REQ-018 In RUN with count_enable=1 and count_out==1 (terminal decrement), expire_flag SHALL be 1 for exactly the next cycle.
REQ-019 At terminal decrement with periodic=1, count_out SHALL load the reload register value next cycle and state SHALL remain RUN.
REQ-020 At terminal decrement with periodic=0, count_out SHALL become 0 and state SHALL become DONE next cycle.
REQ-021 periodic SHALL be sampled only on the terminal-decrement cycle.
REQ-022 In RUN with count_enable=0, count_out and state SHALL hold.
REQ-023 expire_flag SHALL be 0 in every cycle not immediately following a terminal decrement; there is no multi-cycle assertion, even when count_enable stays low.
REQ-024 With reload value 1 and periodic=1, expire_flag SHALL pulse after every enabled cycle and count_out SHALL stay 1.
REQ-025 In IDLE and DONE, count_enable SHALL have no effect; count_out holds 0.
REQ-026 busy SHALL be 1 exactly when state is RUN.
REQ-027 Arithmetic SHALL be unsigned NUM_CNT_BITS wide; the count SHALL never wrap below 0 or exceed the reload value.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-029 On n_rst=0, count_out=0, reload register=0, expire_flag=0, busy=0 and state=IDLE SHALL take effect immediately, regardless of clk.
REQ-030 On n_rst rising, the block SHALL remain in IDLE until a load with nonzero load_val is applied.
REQ-031 Reset asserted mid-count SHALL abort the operation with no expire_flag pulse generated.

Verification
REQ-032 Bench SHALL cover: NUM_CNT_BITS=4, load load_val=5, periodic=0, count_enable held 1 -> count_out 5,4,3,2,1,0; expire_flag=1 only in the cycle count_out first reads 0; busy drops together with it; state DONE.
REQ-033 Bench SHALL cover: load load_val=3, periodic=1, enable held 1 for 9 cycles -> count_out 3,2,1,3,2,1,3,2,1,3; expire_flag pulses three times, each one cycle, coincident with the reload to 3.
REQ-034 Bench SHALL cover: load load_val=4, enable toggled 1,0,0,1,1,1 -> count_out 4,3,3,3,2,1,0; exactly one expire pulse; count holds while enable=0.
REQ-035 Bench SHALL cover: clear and load both asserted with count_out=2 -> count_out=0, state IDLE, no expire; separately, load load_val=7 at count_out=2 -> count_out=7, busy=1.
REQ-036 Bench SHALL cover: load load_val=0 -> count_out=0, busy=0, expire_flag never asserts under enable; also load load_val=1 with periodic=1 and enable held -> expire_flag high every cycle after the first, count_out stays 1.
REQ-037 Bench SHALL cover: n_rst pulsed low asynchronously between edges at count_out=2 -> all outputs 0 immediately, no expire pulse after release.

Source files
------------

// File: rtl/flex_down_timer.sv
// Loadable down-counter with one-shot or auto-reload expiry.
// Emits a one-cycle expire pulse on the terminal decrement; all outputs come straight from flops.
module flex_down_timer #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic                    periodic,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy
);

    localparam int unsigned CW = NUM_CNT_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reload_q, reload_d;
    logic          expire_q, expire_d;
    logic          busy_q, busy_d;

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: clear beats load beats count_enable
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;

        if (clear) begin
            count_d = '0;
            state_d = IDLE;
        end else if (load) begin
            reload_d = load_val;
            if (load_val != '0) begin
                count_d = load_val;
                state_d = RUN;
            end else begin
                count_d = '0;
                state_d = IDLE;
            end
        end else if (state_q == RUN && count_enable) begin
            if (count_q > CW'(1)) begin
                count_d = count_q - CW'(1);
            end else if (count_q == CW'(1)) begin
                // Terminal decrement: periodic only matters here
                expire_d = 1'b1;
                if (periodic) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
        end

        busy_d = (state_d == RUN);
    end

    assign count_out   = count_q;
    assign expire_flag = expire_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_flex_down_timer.sv
// Scoreboard bench for flex_down_timer: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_flex_down_timer;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         exp;
        logic         bsy;
    } obs_t;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         load;
    logic         count_enable;
    logic         periodic;
    logic [W-1:0] load_val;
    logic [W-1:0] count_out;
    logic         expire_flag;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int pushed = 0;
    int popped = 0;
    obs_t sb_q[$];

    // Reference model: remaining ticks, reload value, and whether a countdown is active
    int m_count  = 0;
    int m_reload = 0;
    bit m_active = 0;

    flex_down_timer #(.NUM_CNT_BITS(W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .load        (load),
        .count_enable(count_enable),
        .periodic    (periodic),
        .load_val    (load_val),
        .count_out   (count_out),
        .expire_flag (expire_flag),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a new registered output
    always @(posedge clk) begin
        obs_t e;
        #1;
        if (n_rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            popped++;
            check("count_out", int'(count_out), int'(e.cnt));
            check("expire_flag", int'(expire_flag), int'(e.exp));
            check("busy", int'(busy), int'(e.bsy));
        end
    end

    task automatic step(input logic c, input logic l, input logic e,
                        input logic p, input logic [W-1:0] v);
        bit fire;
        obs_t o;
        @(negedge clk);
        clear = c; load = l; count_enable = e; periodic = p; load_val = v;
        fire = 0;
        if (c) begin
            m_count = 0;
            m_active = 0;
        end else if (l) begin
            m_reload = int'(v);
            m_count  = int'(v);
            m_active = (v != 0);
        end else if (m_active && e) begin
            if (m_count == 1) begin
                fire = 1;
                if (p) m_count = m_reload;
                else begin
                    m_count = 0;
                    m_active = 0;
                end
            end else begin
                m_count = m_count - 1;
            end
        end
        o.cnt = W'(m_count);
        o.exp = fire;
        o.bsy = m_active;
        sb_q.push_back(o);
        pushed++;
        @(posedge clk);
    endtask

    // Reset pulse placed between clock edges; outputs must drop without waiting for clk
    task automatic async_reset();
        #2 n_rst = 1'b0;
        #1;
        check("rst_count", int'(count_out), 0);
        check("rst_expire", int'(expire_flag), 0);
        check("rst_busy", int'(busy), 0);
        m_count = 0; m_reload = 0; m_active = 0;
        #1 n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        clear = 0; load = 0; count_enable = 0; periodic = 0; load_val = '0;
        #12;
        check("por_count", int'(count_out), 0);
        check("por_expire", int'(expire_flag), 0);
        check("por_busy", int'(busy), 0);
        #1 n_rst = 1'b1;

        // Idle ignores enable after reset
        repeat (2) step(0, 0, 1, 1, 4'd0);

        // One-shot from 5
        step(0, 1, 0, 0, 4'd5);
        repeat (6) step(0, 0, 1, 0, 4'd0);

        // Periodic from 3, nine enabled cycles
        step(0, 1, 0, 1, 4'd3);
        repeat (9) step(0, 0, 1, 1, 4'd0);

        // Gappy enable from 4
        step(0, 1, 0, 0, 4'd4);
        step(0, 0, 1, 0, 4'd0);
        step(0, 0, 0, 0, 4'd0);
        step(0, 0, 0, 0, 4'd0);
        repeat (3) step(0, 0, 1, 0, 4'd0);
        step(0, 0, 0, 0, 4'd0);

        // Clear beats load at count 2; then restart mid-count with 7
        step(0, 1, 0, 0, 4'd4);
        repeat (2) step(0, 0, 1, 0, 4'd0);
        step(1, 1, 1, 0, 4'd6);
        step(0, 0, 1, 0, 4'd0);
        step(0, 1, 0, 0, 4'd4);
        repeat (2) step(0, 0, 1, 0, 4'd0);
        step(0, 1, 1, 0, 4'd7);
        repeat (2) step(0, 0, 1, 0, 4'd0);

        // Zero load, then reload value 1 periodic
        step(0, 1, 0, 1, 4'd0);
        repeat (3) step(0, 0, 1, 1, 4'd0);
        step(0, 1, 0, 1, 4'd1);
        repeat (5) step(0, 0, 1, 1, 4'd0);

        // Async reset at count 2
        step(0, 1, 0, 0, 4'd4);
        repeat (2) step(0, 0, 1, 0, 4'd0);
        async_reset();
        repeat (3) step(0, 0, 1, 1, 4'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic c, l, e, p;
            logic [W-1:0] v;
            c = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 9) < 7);
            p = $urandom_range(0, 1);
            v = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 15));
            step(c, l, e, p, v);
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", sb_q.size(), 0);
        check("pushed_vs_popped", popped, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
